forwarding_unit: RTL and testbench

Data-hazard forwarding control for the 5-stage MIPS pipeline, located in the EX stage. It compares the ID/EX source register numbers against the EX/MEM and MEM/WB destination registers. It produces 2-bit mux selects for the two ALU operands. Selects are purely combinational, same cycle. An optional clocked statistics block counts forwarding events.

---
 rtl/fwd_pkg.sv | 12 +
 rtl/fwd_select.sv | 32 +++
 rtl/forwarding_unit.sv | 87 ++++++++
 tb/tb_forwarding_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants for the EX-stage forwarding unit: operand-select encodings
// and default widths.
package fwd_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/fwd_select.sv
// One operand's forwarding decision: compares a source register against the
// MEM and WB destinations and picks the most recent producer.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              ex_mem_wr,
    input  logic              mem_wb_wr,
    output logic [1:0]        sel
);

    logic ex_hit;
    logic mem_hit;

    // r0 is hard-wired zero, so a write to it must never be forwarded.
    assign ex_hit  = ex_mem_wr && (ex_mem_rd != '0) && (ex_mem_rd == src);
    assign mem_hit = mem_wb_wr && (mem_wb_rd != '0) && (mem_wb_rd == src);

    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX_MEM;
        end else if (mem_hit) begin
            sel = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage data-hazard forwarding control with optional saturating event
// counters, enabled by defining FWD_STATS_EN.
module forwarding_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    input  logic [REG_AW-1:0] ID_EX_rs,
    input  logic [REG_AW-1:0] ID_EX_rt,
    input  logic [REG_AW-1:0] EX_MEM_rd,
    input  logic [REG_AW-1:0] MEM_WB_rd,
    input  logic              MEM_WB_RegWrite,
    input  logic              EX_MEM_RegWrite,
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  fwd_ex_cnt,
    output logic [CNT_W-1:0]  fwd_mem_cnt
);

    fwd_select #(.REG_AW(REG_AW)) u_sel_a (
        .src       (ID_EX_rs),
        .ex_mem_rd (EX_MEM_rd),
        .mem_wb_rd (MEM_WB_rd),
        .ex_mem_wr (EX_MEM_RegWrite),
        .mem_wb_wr (MEM_WB_RegWrite),
        .sel       (forwardA)
    );

    fwd_select #(.REG_AW(REG_AW)) u_sel_b (
        .src       (ID_EX_rt),
        .ex_mem_rd (EX_MEM_rd),
        .mem_wb_rd (MEM_WB_rd),
        .ex_mem_wr (EX_MEM_RegWrite),
        .mem_wb_wr (MEM_WB_RegWrite),
        .sel       (forwardB)
    );

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] ex_cnt_p1;
    logic [CNT_W-1:0] mem_cnt_p1;
    logic [1:0]       ex_inc;
    logic [1:0]       mem_inc;

    // Widened sum so an increment of 2 near the top clamps instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
        if (sum > {2'b00, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        ex_inc  = {1'b0, forwardA == FWD_EX_MEM} + {1'b0, forwardB == FWD_EX_MEM};
        mem_inc = {1'b0, forwardA == FWD_MEM_WB} + {1'b0, forwardB == FWD_MEM_WB};
    end

    // Statistics stage: one update per cycle, clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cnt_p1  <= '0;
            mem_cnt_p1 <= '0;
        end else if (stats_clr) begin
            ex_cnt_p1  <= '0;
            mem_cnt_p1 <= '0;
        end else begin
            ex_cnt_p1  <= sat_add(ex_cnt_p1, ex_inc);
            mem_cnt_p1 <= sat_add(mem_cnt_p1, mem_inc);
        end
    end

    assign fwd_ex_cnt  = ex_cnt_p1;
    assign fwd_mem_cnt = mem_cnt_p1;
`else
    logic unused_stats;
    assign unused_stats = ^{clk, rst_n, stats_clr};
    assign fwd_ex_cnt   = '0;
    assign fwd_mem_cnt  = '0;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed plus randomized bench for forwarding_unit; counter expectations
// follow FWD_STATS_EN (zero when the statistics block is compiled out).
module tb_forwarding_unit;

`ifdef FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stats_clr;
    logic [4:0] rs, rt, exrd, mwrd;
    logic       exwr, mwwr;
    logic [1:0] fa, fb, fa2, fb2;
    logic [15:0] ex_cnt, mem_cnt;
    logic [1:0]  ex_cnt2, mem_cnt2;

    int errors = 0;
    int checks = 0;
    int exp_ex = 0, exp_mem = 0, exp_ex2 = 0, exp_mem2 = 0;

    always #5 clk = ~clk;

    forwarding_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .forwardA(fa), .forwardB(fb), .ID_EX_rs(rs), .ID_EX_rt(rt),
        .EX_MEM_rd(exrd), .MEM_WB_rd(mwrd), .MEM_WB_RegWrite(mwwr),
        .EX_MEM_RegWrite(exwr), .clk(clk), .rst_n(rst_n), .stats_clr(stats_clr),
        .fwd_ex_cnt(ex_cnt), .fwd_mem_cnt(mem_cnt)
    );

    forwarding_unit #(.REG_AW(5), .CNT_W(2)) dut2 (
        .forwardA(fa2), .forwardB(fb2), .ID_EX_rs(rs), .ID_EX_rt(rt),
        .EX_MEM_rd(exrd), .MEM_WB_rd(mwrd), .MEM_WB_RegWrite(mwwr),
        .EX_MEM_RegWrite(exwr), .clk(clk), .rst_n(rst_n), .stats_clr(stats_clr),
        .fwd_ex_cnt(ex_cnt2), .fwd_mem_cnt(mem_cnt2)
    );

    // Reference: the newest writer of a nonzero source register supplies it.
    function automatic logic [1:0] ref_sel(input int src, input int e_rd, input int m_rd,
                                           input bit e_wr, input bit m_wr);
        if (src == 0) return 2'b00;
        if (e_wr && e_rd == src) return 2'b10;
        if (m_wr && m_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int e_rd, input int m_rd,
                         input bit e_wr, input bit m_wr);
        rs = 5'(a); rt = 5'(b); exrd = 5'(e_rd); mwrd = 5'(m_rd);
        exwr = e_wr; mwwr = m_wr;
    endtask

    task automatic check_sel(input string tag);
        logic [1:0] ea, eb;
        #1;
        ea = ref_sel(int'(rs), int'(exrd), int'(mwrd), exwr, mwwr);
        eb = ref_sel(int'(rt), int'(exrd), int'(mwrd), exwr, mwwr);
        check({tag, "_A"}, 32'(fa), 32'(ea));
        check({tag, "_B"}, 32'(fb), 32'(eb));
        check({tag, "_A2"}, 32'(fa2), 32'(ea));
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_ex"}, 32'(ex_cnt), 32'(exp_ex));
        check({tag, "_mem"}, 32'(mem_cnt), 32'(exp_mem));
        check({tag, "_ex2"}, 32'(ex_cnt2), 32'(exp_ex2));
        check({tag, "_mem2"}, 32'(mem_cnt2), 32'(exp_mem2));
    endtask

    // Advance one rising edge, update the counter model, compare counters.
    task automatic tick(input string tag);
        int ie, im;
        logic [1:0] ea, eb;
        ea = ref_sel(int'(rs), int'(exrd), int'(mwrd), exwr, mwwr);
        eb = ref_sel(int'(rt), int'(exrd), int'(mwrd), exwr, mwwr);
        ie = int'(ea == 2'b10) + int'(eb == 2'b10);
        im = int'(ea == 2'b01) + int'(eb == 2'b01);
        @(posedge clk);
        if (STATS && rst_n) begin
            if (stats_clr) begin
                exp_ex = 0; exp_mem = 0; exp_ex2 = 0; exp_mem2 = 0;
            end else begin
                exp_ex   = sat(exp_ex + ie, 65535);
                exp_mem  = sat(exp_mem + im, 65535);
                exp_ex2  = sat(exp_ex2 + ie, 3);
                exp_mem2 = sat(exp_mem2 + im, 3);
            end
        end
        #1;
        check_cnt(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        stats_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_cnt("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed select cases, including constant expectations.
        drive(5, 7, 5, 0, 1, 0); check_sel("ex_only");
        check("ex_only_constA", 32'(fa), 32'h2);
        check("ex_only_constB", 32'(fb), 32'h0);
        drive(5, 5, 5, 0, 1, 0); check_sel("rs_eq_rt");
        drive(5, 5, 5, 5, 1, 1); check_sel("priority");
        check("priority_constA", 32'(fa), 32'h2);
        check("priority_constB", 32'(fb), 32'h2);
        drive(5, 5, 5, 5, 0, 1); check_sel("mem_only");
        check("mem_only_constA", 32'(fa), 32'h1);
        check("mem_only_constB", 32'(fb), 32'h1);
        drive(5, 5, 5, 5, 0, 0); check_sel("none");
        check("none_const", 32'({fa, fb}), 32'h0);
        drive(0, 0, 0, 0, 1, 1); check_sel("r0_guard");
        check("r0_guard_const", 32'({fa, fb}), 32'h0);
        drive(0, 9, 9, 0, 0, 1); check_sel("mixed");

        // Clear, then hold the 10/10 case for three edges.
        @(negedge clk);
        drive(5, 5, 5, 5, 1, 1);
        stats_clr = 1'b1;
        tick("clr0");
        @(negedge clk);
        stats_clr = 1'b0;
        tick("hold1"); tick("hold2"); tick("hold3");
        check("hold_ex_final", 32'(ex_cnt), STATS ? 32'd6 : 32'd0);
        check("hold_sat_final", 32'(ex_cnt2), STATS ? 32'd3 : 32'd0);
        @(negedge clk);
        stats_clr = 1'b1;
        tick("clr1");
        check("clr_const", 32'(ex_cnt), 32'd0);
        @(negedge clk);
        stats_clr = 1'b0;
        tick("recount");

        // Asynchronous reset mid-cycle: counters drop at once, selects unaffected.
        #2;
        rst_n = 1'b0;
        exp_ex = 0; exp_mem = 0; exp_ex2 = 0; exp_mem2 = 0;
        #1;
        check_cnt("async_rst");
        check_sel("sel_in_rst");
        tick("held_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic over a small register range to force collisions.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stats_clr = ($urandom_range(0, 19) == 0);
            check_sel("rand");
            tick("rand_cnt");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
